// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready bus for one side of an elastic pipeline stage: a payload plus a control field.
// The master drives valid/data/ctrl; the slave drives ready.
interface pipe_stage_elastic_if #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8
) ();
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input ready);
    modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with a 2-entry skid buffer and a registered upstream ready.
// Optional saturating perf counters are enabled with the PIPE_STAGE_PERF_CNT_EN macro.
module pipe_stage_elastic #(
    parameter int                 DATA_W    = 64,
    parameter int                 CTRL_W    = 8,
    parameter logic [CTRL_W-1:0]  CTRL_SAFE = {CTRL_W{1'b0}},
    parameter int                 CNT_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    pipe_stage_elastic_if.slave   up,
    pipe_stage_elastic_if.master  dn,
    output logic [1:0]            dbg_state
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      bubble_cnt,
    output logic [CNT_W-1:0]      flush_cnt
`endif
);

    // Handshake: a beat transfers on a rising edge where valid & ready are both high;
    // valid and its payload hold until that edge, and ready never depends on valid.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_e;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_ready;
    logic              in_fire;
    logic              out_fire;

    assign in_ready  = (state_q != S_TWO);
    assign up.ready  = in_ready;
    assign dn.valid  = (state_q != S_EMPTY);
    assign dn.data   = main_data_q;
    // An empty slot must never present a live control word downstream.
    assign dn.ctrl   = (state_q != S_EMPTY) ? main_ctrl_q : CTRL_SAFE;
    assign dbg_state = state_q;

    assign in_fire  = up.valid & in_ready;
    assign out_fire = dn.valid & dn.ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            state_d     = S_EMPTY;
            main_data_d = '0;
            main_ctrl_d = CTRL_SAFE;
            skid_data_d = '0;
            skid_ctrl_d = CTRL_SAFE;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_fire) begin
                        state_d     = S_ONE;
                        main_data_d = up.data;
                        main_ctrl_d = up.ctrl;
                    end
                end
                S_ONE: begin
                    if (in_fire && out_fire) begin
                        main_data_d = up.data;
                        main_ctrl_d = up.ctrl;
                    end else if (in_fire) begin
                        state_d     = S_TWO;
                        skid_data_d = up.data;
                        skid_ctrl_d = up.ctrl;
                    end else if (out_fire) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (out_fire) begin
                        state_d     = S_ONE;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= CTRL_SAFE;
            skid_data_q <= '0;
            skid_ctrl_q <= CTRL_SAFE;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Counters saturate and survive flush; only reset clears them.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (dn.valid && !dn.ready && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (!dn.valid && (bubble_cnt_q != {CNT_W{1'b1}}))
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        if (flush && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: FIFO-queue reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_pipe_stage_elastic;
    localparam int DATA_W = 64;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 32;
    localparam logic [CTRL_W-1:0] SAFE = '0;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [1:0] dbg_state;
`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, bubble_cnt, flush_cnt;
`endif

    pipe_stage_elastic_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) up_if ();
    pipe_stage_elastic_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dn_if ();

    pipe_stage_elastic #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_SAFE(SAFE), .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .flush     (flush),
        .up        (up_if.slave),
        .dn        (dn_if.master),
        .dbg_state (dbg_state)
`ifdef PIPE_STAGE_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total_cnt = 0;
    int pass_cnt  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model: entries as {ctrl, data} ----------------
    logic [CTRL_W+DATA_W-1:0] exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
        end else if (flush) begin
            exp_q.delete();
        end else begin
            bit can_take;
            can_take = (exp_q.size() < 2);
            if (exp_q.size() > 0 && dn_if.ready) void'(exp_q.pop_front());
            if (up_if.valid && can_take) exp_q.push_back({up_if.ctrl, up_if.data});
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        check("model_out_valid", 64'(dn_if.valid), 64'(exp_q.size() != 0));
        check("model_in_ready", 64'(up_if.ready), 64'(exp_q.size() < 2));
        if (exp_q.size() != 0) begin
            check("model_out_data", dn_if.data, exp_q[0][DATA_W-1:0]);
            check("model_out_ctrl", 64'(dn_if.ctrl), 64'(exp_q[0][CTRL_W+DATA_W-1:DATA_W]));
        end else begin
            check("model_idle_ctrl", 64'(dn_if.ctrl), 64'(SAFE));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input logic v, input logic [63:0] d, input logic [7:0] c);
        up_if.valid = v;
        up_if.data  = d;
        up_if.ctrl  = c;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        drive_in(1'b0, 64'h0, 8'h0);
        dn_if.ready = 1'b0;
        repeat (2) step();

        check("reset_out_valid", 64'(dn_if.valid), 64'd0);
        check("reset_in_ready", 64'(up_if.ready), 64'd1);
        check("reset_out_data", dn_if.data, 64'd0);
        check("reset_out_ctrl", 64'(dn_if.ctrl), 64'h00);
        check("reset_state", 64'(dbg_state), 64'd0);

        // Stream 1..8 with out_ready held high.
        @(negedge clk);
        rst_n = 1'b1;
        dn_if.ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive_in(1'b1, 64'(i), 8'(i));
            step();
            check("stream_valid", 64'(dn_if.valid), 64'd1);
            check("stream_data", dn_if.data, 64'(i));
            check("stream_in_ready", 64'(up_if.ready), 64'd1);
        end
        drive_in(1'b0, 64'h0, 8'h0);
        step();
        check("stream_drained", 64'(dn_if.valid), 64'd0);

        // Backpressure fill, then drain A then B.
        dn_if.ready = 1'b0;
        drive_in(1'b1, 64'h11, 8'h01);
        step();
        check("bp_one_ready", 64'(up_if.ready), 64'd1);
        drive_in(1'b1, 64'h22, 8'h02);
        step();
        check("bp_two_ready", 64'(up_if.ready), 64'd0);
        check("bp_two_state", 64'(dbg_state), 64'd2);
        check("bp_head_a", dn_if.data, 64'h11);
        drive_in(1'b0, 64'h0, 8'h0);
        step();
        check("bp_still_full", 64'(up_if.ready), 64'd0);
        dn_if.ready = 1'b1;
        step();
        check("bp_head_b", dn_if.data, 64'h22);
        check("bp_ready_back", 64'(up_if.ready), 64'd1);
        step();
        check("bp_empty", 64'(dn_if.valid), 64'd0);

        // Flush while full; C must be dropped.
        dn_if.ready = 1'b0;
        drive_in(1'b1, 64'h44, 8'h04);
        step();
        drive_in(1'b1, 64'h55, 8'h05);
        step();
        check("fl_full", 64'(dbg_state), 64'd2);
        flush = 1'b1;
        drive_in(1'b1, 64'h33, 8'hAA);
        step();
        flush = 1'b0;
        drive_in(1'b0, 64'h0, 8'h0);
        check("fl_out_valid", 64'(dn_if.valid), 64'd0);
        check("fl_out_ctrl", 64'(dn_if.ctrl), 64'h00);
        check("fl_out_data", dn_if.data, 64'd0);
        check("fl_in_ready", 64'(up_if.ready), 64'd1);
        dn_if.ready = 1'b1;
        repeat (2) begin
            step();
            check("fl_no_c", 64'(dn_if.valid), 64'd0);
        end

        // Bubble after a beat with all control bits set.
        drive_in(1'b1, 64'h66, 8'hFF);
        step();
        check("bub_beat_ctrl", 64'(dn_if.ctrl), 64'hFF);
        drive_in(1'b0, 64'h0, 8'h0);
        step();
        check("bub_valid", 64'(dn_if.valid), 64'd0);
        check("bub_ctrl", 64'(dn_if.ctrl), 64'h00);

        // Asynchronous reset between edges with the buffer full.
        dn_if.ready = 1'b0;
        drive_in(1'b1, 64'h77, 8'h07);
        step();
        drive_in(1'b1, 64'h88, 8'h08);
        step();
        drive_in(1'b0, 64'h0, 8'h0);
        check("ar_full", 64'(up_if.ready), 64'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", 64'(dn_if.valid), 64'd0);
        check("ar_in_ready", 64'(up_if.ready), 64'd1);
        check("ar_out_ctrl", 64'(dn_if.ctrl), 64'h00);
        check("ar_out_data", dn_if.data, 64'd0);
        step();

        // Counter scenario: 2 bubbles, 3 stalls, 1 flush.
        @(negedge clk);
        rst_n = 1'b1;
        drive_in(1'b1, 64'h99, 8'h09);
        step();
        drive_in(1'b0, 64'h0, 8'h0);
        repeat (3) step();
        flush = 1'b1;
        dn_if.ready = 1'b1;
        step();
        flush = 1'b0;
        dn_if.ready = 1'b0;
        step();
        check("cnt_end_valid", 64'(dn_if.valid), 64'd0);
`ifdef PIPE_STAGE_PERF_CNT_EN
        check("stall_cnt", 64'(stall_cnt), 64'd3);
        check("bubble_cnt", 64'(bubble_cnt), 64'd2);
        check("flush_cnt", 64'(flush_cnt), 64'd1);
`endif

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
